// File: rtl/ibus_arbiter_pkg.sv
// Shared encodings for the instruction-bus arbiter: bus sizes, FSM states, reset vector.
package ibus_arbiter_pkg;

  localparam logic [1:0] SIZ_NONE = 2'b00;
  localparam logic [1:0] SIZ_WORD = 2'b10;

  localparam logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  function automatic logic is_req(input logic [1:0] siz);
    return siz != SIZ_NONE;
  endfunction

endpackage

// File: rtl/ibus_timeout_counter.sv
// Wait-cycle counter for a granted transfer; expire is combinational on count==TIMEOUT-1.
// Clear wins over enable; the count only advances while a transfer is owned.
module ibus_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/ibus_arbiter.sv
// Round-robin two-master arbiter for the instruction bus; one-cycle grant latency, then
// address/size/ack/data pass straight through until ack, requester abort or timeout.
module ibus_arbiter
  import ibus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] m0_adr_i,
  input  logic [1:0]  m0_siz_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic [63:0] m1_adr_i,
  input  logic [1:0]  m1_siz_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  input  logic        iack_i,
  input  logic [31:0] idat_i,
  output logic [63:0] iadr_o,
  output logic [1:0]  isiz_o,
  output logic        jammed_o
);

  state_t state;
  logic   rr_last;
  logic   jammed;
  logic   expire;
  logic   req0, req1;
  logic   own0, own1;
  logic   leave;

  assign req0 = is_req(m0_siz_i);
  assign req1 = is_req(m1_siz_i);

  // Gating with reset keeps every output quiet for the whole time reset is held.
  assign own0 = (state == OWN0) && !reset_i;
  assign own1 = (state == OWN1) && !reset_i;

  assign leave = (own0 && (iack_i || !req0 || expire))
              || (own1 && (iack_i || !req1 || expire));

  ibus_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear  (!(own0 || own1) || leave),
    .enable (own0 || own1),
    .expire (expire)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      jammed  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            state <= rr_last ? OWN0 : OWN1;
          end else if (req0) begin
            state <= OWN0;
          end else if (req1) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          if (iack_i) begin
            state   <= IDLE;
            rr_last <= 1'b0;
          end else if (!req0) begin
            state <= IDLE;
          end else if (expire) begin
            state   <= IDLE;
            rr_last <= 1'b0;
            jammed  <= 1'b1;
          end
        end
        OWN1: begin
          if (iack_i) begin
            state   <= IDLE;
            rr_last <= 1'b1;
          end else if (!req1) begin
            state <= IDLE;
          end else if (expire) begin
            state   <= IDLE;
            rr_last <= 1'b1;
            jammed  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iadr_o   = '0;
    isiz_o   = SIZ_NONE;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    if (own0) begin
      iadr_o   = m0_adr_i;
      isiz_o   = m0_siz_i;
      m0_ack_o = iack_i;
      m0_err_o = !iack_i && req0 && expire;
      m0_dat_o = idat_i;
    end else if (own1) begin
      iadr_o   = m1_adr_i;
      isiz_o   = m1_siz_i;
      m1_ack_o = iack_i;
      m1_err_o = !iack_i && req1 && expire;
      m1_dat_o = idat_i;
    end
  end

  assign jammed_o = jammed && !reset_i;

endmodule
